// File: rtl/alu_top.sv
// Self-sequencing 8-bit ALU: walks steps 0..15 after reset, writing results/flags into two 16x8 transfer memories.
// Optional ALU_SATURATE_EN: ADD/INC clamp to all-ones on carry, SUB/DEC clamp to zero on borrow.
module alu_top #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Trans_Mem1_ADDRB,
  input  logic              Trans_Mem1_RENB,
  output logic [DATA_W-1:0] Trans_Mem1_DOUTB,
  input  logic [ADDR_W-1:0] Trans_Mem2_ADDRB,
  input  logic              Trans_Mem2_RENB,
  output logic [DATA_W-1:0] Trans_Mem2_DOUTB
);

  localparam int unsigned MSB = DATA_W - 1;
  localparam logic [DATA_W:0] L_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR,
    OP_ROL, OP_ROR, OP_INC, OP_DEC, OP_MUL, OP_CMP, OP_PASSA, OP_PASSB
  } op_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_step;
  logic [DATA_W-1:0]   r_mem1 [DEPTH];
  logic [DATA_W-1:0]   r_mem2 [DEPTH];
  logic [DATA_W-1:0]   r_dout1;
  logic [DATA_W-1:0]   r_dout2;

  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;
  op_t                 w_op;
  logic [DATA_W:0]     w_add;
  logic [DATA_W:0]     w_sub;
  logic [DATA_W:0]     w_inc;
  logic [DATA_W:0]     w_dec;
  logic [2*DATA_W-1:0] w_mul;
  logic [DATA_W-1:0]   w_res;
  logic [DATA_W-1:0]   w_zn;
  logic                w_c;
  logic                w_v;
  logic [DATA_W-1:0]   w_flags;
  logic                w_we;

  // Operands and opcode are pure functions of the current step.
  assign w_a   = {r_step, 4'h5};
  assign w_b   = {4'h3, r_step};
  assign w_op  = op_t'(r_step);
  assign w_add = {1'b0, w_a} + {1'b0, w_b};
  assign w_sub = {1'b0, w_a} - {1'b0, w_b};
  assign w_inc = {1'b0, w_a} + L_ONE;
  assign w_dec = {1'b0, w_a} - L_ONE;
  assign w_mul = {{DATA_W{1'b0}}, w_a} * {{DATA_W{1'b0}}, w_b};
  assign w_we  = (r_state == S_RUN);

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_zn  = '0;
    case (w_op)
      OP_ADD: begin
        w_res = w_add[MSB:0];
        w_c   = w_add[DATA_W];
        w_v   = (w_a[MSB] == w_b[MSB]) && (w_add[MSB] != w_a[MSB]);
`ifdef ALU_SATURATE_EN
        if (w_add[DATA_W]) w_res = '1;
`endif
      end
      OP_SUB: begin
        w_res = w_sub[MSB:0];
        w_c   = w_sub[DATA_W];
        w_v   = (w_a[MSB] != w_b[MSB]) && (w_sub[MSB] != w_a[MSB]);
`ifdef ALU_SATURATE_EN
        if (w_sub[DATA_W]) w_res = '0;
`endif
      end
      OP_AND:   w_res = w_a & w_b;
      OP_OR:    w_res = w_a | w_b;
      OP_XOR:   w_res = w_a ^ w_b;
      OP_NOT:   w_res = ~w_a;
      OP_SHL: begin
        w_res = {w_a[MSB-1:0], 1'b0};
        w_c   = w_a[MSB];
      end
      OP_SHR: begin
        w_res = {1'b0, w_a[MSB:1]};
        w_c   = w_a[0];
      end
      OP_ROL: begin
        w_res = {w_a[MSB-1:0], w_a[MSB]};
        w_c   = w_a[MSB];
      end
      OP_ROR: begin
        w_res = {w_a[0], w_a[MSB:1]};
        w_c   = w_a[0];
      end
      OP_INC: begin
        w_res = w_inc[MSB:0];
        w_c   = w_inc[DATA_W];
        w_v   = ~w_a[MSB] & w_inc[MSB];
`ifdef ALU_SATURATE_EN
        if (w_inc[DATA_W]) w_res = '1;
`endif
      end
      OP_DEC: begin
        w_res = w_dec[MSB:0];
        w_c   = w_dec[DATA_W];
        w_v   = w_a[MSB] & ~w_dec[MSB];
`ifdef ALU_SATURATE_EN
        if (w_dec[DATA_W]) w_res = '0;
`endif
      end
      OP_MUL: begin
        w_res = w_mul[MSB:0];
        w_c   = |w_mul[2*DATA_W-1:DATA_W];
      end
      OP_CMP: begin
        w_res = '0;
        w_c   = w_sub[DATA_W];
        w_v   = (w_a[MSB] != w_b[MSB]) && (w_sub[MSB] != w_a[MSB]);
      end
      OP_PASSA: w_res = w_a;
      OP_PASSB: w_res = w_b;
      default:  w_res = '0;
    endcase
    // CMP reports Z/N of the difference while storing a zero result.
    if (w_op == OP_CMP) w_zn = w_sub[MSB:0];
    else                w_zn = w_res;
  end

  assign w_flags = {w_c, ~|w_zn, w_zn[MSB], w_v, {(DATA_W-4){1'b0}}};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_step  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_RUN;
          r_step  <= '0;
        end
        S_RUN: begin
          if (r_step == ADDR_W'(DEPTH - 1)) r_state <= S_DONE;
          else                              r_step  <= r_step + ADDR_W'(1);
        end
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_mem1[k] <= '0;
        r_mem2[k] <= '0;
      end
    end else if (w_we) begin
      r_mem1[r_step] <= w_res;
      r_mem2[r_step] <= w_flags;
    end
  end

  // Port-B reads sample the pre-write array contents, giving read-before-write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dout1 <= '0;
      r_dout2 <= '0;
    end else begin
      if (Trans_Mem1_RENB) r_dout1 <= r_mem1[Trans_Mem1_ADDRB];
      if (Trans_Mem2_RENB) r_dout2 <= r_mem2[Trans_Mem2_ADDRB];
    end
  end

  assign Trans_Mem1_DOUTB = r_dout1;
  assign Trans_Mem2_DOUTB = r_dout2;

endmodule

// File: tb/tb_alu_top.sv
// Self-checking bench for alu_top: arithmetic reference model, fixed vectors, random port-B reads, mid-run reset.
module tb_alu_top;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] m1_addr = '0;
  logic       m1_ren = 1'b0;
  logic [7:0] m1_dout;
  logic [3:0] m2_addr = '0;
  logic       m2_ren = 1'b0;
  logic [7:0] m2_dout;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp1 = '0;
  logic [7:0] exp2 = '0;

  always #5 clock = ~clock;

  alu_top #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) dut (
    .clock            (clock),
    .reset            (reset),
    .Trans_Mem1_ADDRB (m1_addr),
    .Trans_Mem1_RENB  (m1_ren),
    .Trans_Mem1_DOUTB (m1_dout),
    .Trans_Mem2_ADDRB (m2_addr),
    .Trans_Mem2_RENB  (m2_ren),
    .Trans_Mem2_DOUTB (m2_dout)
  );

  function automatic int sgn(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  // Reference: integer arithmetic straight from the opcode table.
  function automatic void model(input int i, output logic [7:0] r, output logic [7:0] f);
    int a, b, t, rr, zn;
    logic c, v;
    a = i * 16 + 5;
    b = 48 + i;
    c = 1'b0;
    v = 1'b0;
    rr = 0;
    case (i)
      0:  begin t = a + b; rr = t % 256; c = (t > 255); v = (sgn(a) + sgn(b) > 127) || (sgn(a) + sgn(b) < -128); end
      1:  begin t = a - b; rr = (t + 256) % 256; c = (a < b); v = (sgn(a) - sgn(b) > 127) || (sgn(a) - sgn(b) < -128); end
      2:  rr = a & b;
      3:  rr = a | b;
      4:  rr = a ^ b;
      5:  rr = 255 - a;
      6:  begin rr = (a * 2) % 256; c = (a >= 128); end
      7:  begin rr = a / 2; c = (a % 2 == 1); end
      8:  begin rr = (a * 2) % 256 + a / 128; c = (a >= 128); end
      9:  begin rr = a / 2 + (a % 2) * 128; c = (a % 2 == 1); end
      10: begin t = a + 1; rr = t % 256; c = (t > 255); v = (sgn(a) + 1 > 127); end
      11: begin t = a - 1; rr = (t + 256) % 256; c = (a == 0); v = (sgn(a) - 1 < -128); end
      12: begin t = a * b; rr = t % 256; c = (t > 255); end
      13: begin t = a - b; rr = 0; c = (a < b); v = (sgn(a) - sgn(b) > 127) || (sgn(a) - sgn(b) < -128); end
      14: rr = a;
      default: rr = b;
    endcase
    zn = (i == 13) ? ((a - b + 256) % 256) : rr;
    r = rr[7:0];
    f = {c, (zn == 0), (zn >= 128), v, 4'b0000};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_both(input string name, input logic [7:0] e1, input logic [7:0] e2);
    n_checks++;
    if (m1_dout !== e1) begin
      n_fail++;
      $display("FAIL %s mem1: got %02h expected %02h", name, m1_dout, e1);
    end
    n_checks++;
    if (m2_dout !== e2) begin
      n_fail++;
      $display("FAIL %s mem2: got %02h expected %02h", name, m2_dout, e2);
    end
  endtask

  task automatic read_all(input string name);
    logic [7:0] r, f;
    for (int a = 0; a < 16; a++) begin
      m1_addr = 4'(a); m2_addr = 4'(a);
      m1_ren = 1'b1;   m2_ren = 1'b1;
      tick();
      model(a, r, f);
      exp1 = r; exp2 = f;
      check_both($sformatf("%s addr%0d", name, a), exp1, exp2);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    m1_addr = '0; m2_addr = '0;
    m1_ren = 1'b1; m2_ren = 1'b1;
    repeat (3) tick();
    check_both("reset_read0", 8'h00, 8'h00);
  endtask

  task automatic test_full_run();
    reset = 1'b1;
    repeat (20) tick();
    read_all("full_run");
  endtask

  task automatic test_plan_vectors();
    logic [7:0] e1 [6];
    logic [7:0] e2 [6];
    int         ad [6];
    ad = '{0, 1, 2, 3, 12, 13};
    e1 = '{8'h35, 8'hE4, 8'h20, 8'h37, 8'h2C, 8'h00};
    e2 = '{8'h00, 8'hA0, 8'h00, 8'h00, 8'h80, 8'h20};
    for (int k = 0; k < 6; k++) begin
      m1_addr = 4'(ad[k]); m2_addr = 4'(ad[k]);
      m1_ren = 1'b1; m2_ren = 1'b1;
      tick();
      exp1 = e1[k]; exp2 = e2[k];
      check_both($sformatf("plan addr%0d", ad[k]), exp1, exp2);
    end
  endtask

  task automatic test_hold();
    logic [7:0] r, f;
    m1_addr = 4'd0; m2_addr = 4'd0;
    m1_ren = 1'b1; m2_ren = 1'b1;
    tick();
    model(0, r, f);
    exp1 = r; exp2 = f;
    check_both("hold_first", exp1, exp2);
    m1_ren = 1'b0; m2_ren = 1'b0;
    m1_addr = 4'd7; m2_addr = 4'd7;
    tick();
    check_both("hold_ren0_a", exp1, exp2);
    tick();
    check_both("hold_ren0_b", exp1, exp2);
    m1_ren = 1'b1; m2_ren = 1'b1;
    tick();
    model(7, r, f);
    exp1 = r; exp2 = f;
    check_both("hold_reenable", exp1, exp2);
  endtask

  task automatic test_random_reads();
    logic [7:0] r, f, dummy;
    for (int n = 0; n < 40; n++) begin
      m1_addr = 4'($urandom_range(0, 15));
      m2_addr = 4'($urandom_range(0, 15));
      m1_ren  = 1'($urandom_range(0, 1));
      m2_ren  = 1'($urandom_range(0, 1));
      tick();
      if (m1_ren) begin model(int'(m1_addr), r, dummy); exp1 = r; end
      if (m2_ren) begin model(int'(m2_addr), dummy, f); exp2 = f; end
      check_both($sformatf("random%0d", n), exp1, exp2);
    end
  endtask

  task automatic test_midrun_reset();
    logic [7:0] r3, f3, r1, f1;
    model(3, r3, f3);
    model(1, r1, f1);
    reset = 1'b0;
    #1;
    check_both("async_reset_clear", 8'h00, 8'h00);
    tick(); tick();
    m1_addr = 4'd3; m2_addr = 4'd1;
    m1_ren = 1'b1;  m2_ren = 1'b1;
    reset = 1'b1;
    // Entry k is written on edge k+2 after release; a same-edge read returns old data.
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp1 = (k >= 6) ? r3 : 8'h00;
      exp2 = (k >= 4) ? f1 : 8'h00;
      check_both($sformatf("rbw_edge%0d", k), exp1, exp2);
    end
    reset = 1'b0;
    #1;
    check_both("midrun_reset_clear", 8'h00, 8'h00);
    tick(); tick();
    m1_addr = 4'd15; m2_addr = 4'd14;
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_both($sformatf("no_stale_edge%0d", k), 8'h00, 8'h00);
    end
    repeat (20) tick();
    read_all("restart");
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_plan_vectors();
    test_hold();
    test_random_reads();
    test_midrun_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
